// File: rtl/interrupt_ack_sequencer.sv
// interrupt_ack_sequencer
//   In-service sequencing for an 8259A-style interrupt controller (8086 mode).
//   Resolves the highest-priority pending request against the in-service
//   bits, raises int_out, and runs the two-pulse INTA handshake. It also
//   emits the one-cycle ISR set/clear vectors and owns the rotating
//   priority pointer.
//
// Ports
//   clk, reset                  clock, async active-high reset
//   interrupt_request[7:0]      masked pending requests (IRR & ~IMR)
//   in_service_register[7:0]    current ISR contents
//   inta_n                      CPU acknowledge, active-low, clk-synchronous
//   auto_eoi_mode               ICW4 AEOI
//   vector_base[4:0]            ICW2 T7-T3
//   eoi_command_valid/_command/_level   OCW2 write pulse, R/SL/EOI, L2-L0
//   int_out                     interrupt request to CPU
//   acknowledge                 one-cycle pulse, ISR |= highest_priority_interrupt
//   highest_priority_interrupt  one-hot level being acknowledged
//   end_of_interrupt            one-hot ISR clear vector (one cycle)
//   data_out, data_out_enable   vector byte and bus drive enable
//   priority_bottom             lowest-priority level
module interrupt_ack_sequencer #(
  parameter int NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] interrupt_request,
  input  logic [NUM_IRQ-1:0] in_service_register,
  input  logic               inta_n,
  input  logic               auto_eoi_mode,
  input  logic [4:0]         vector_base,
  input  logic               eoi_command_valid,
  input  logic [2:0]         eoi_command,
  input  logic [2:0]         eoi_level,
  output logic               int_out,
  output logic               acknowledge,
  output logic [NUM_IRQ-1:0] highest_priority_interrupt,
  output logic [NUM_IRQ-1:0] end_of_interrupt,
  output logic [7:0]         data_out,
  output logic               data_out_enable,
  output logic [2:0]         priority_bottom
);

  typedef enum logic [2:0] {IDLE, REQ, ACK1, GAP, ACK2} state_t;

  state_t state, state_d;
  logic   inta_n_q;
  logic   inta_fall, inta_rise;

  // Latched handshake context
  logic [NUM_IRQ-1:0] lat, lat_d;
  logic [2:0]         lat_level, lat_level_d;
  logic               spurious, spurious_d;
  logic               rotate_aeoi, rotate_aeoi_d;

  // Next values of the registered outputs
  logic               int_out_d, acknowledge_d, data_out_enable_d;
  logic [NUM_IRQ-1:0] hpi_d, eoi_d, aeoi_clr, ocw_clr;
  logic [7:0]         data_out_d;
  logic [2:0]         bottom_d;

  // Priority resolution
  logic [3:0]         req_scan, isr_scan;
  logic [2:0]         req_level, isr_top_level;
  logic               res_ok;
  logic [NUM_IRQ-1:0] resolved;

  // Returns {found, rank} of the highest-priority set bit, where rank 0 is
  // level bottom+1. Iterating downward lets the lowest rank win.
  function automatic logic [3:0] scan(input logic [NUM_IRQ-1:0] vec,
                                      input logic [2:0] bottom);
    logic [3:0] r;
    logic [2:0] lvl;
    r = 4'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      lvl = bottom + 3'(i) + 3'd1;
      if (vec[lvl]) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  assign inta_fall = inta_n_q & ~inta_n;
  assign inta_rise = ~inta_n_q & inta_n;

  always_comb begin
    req_scan      = scan(interrupt_request, priority_bottom);
    isr_scan      = scan(in_service_register, priority_bottom);
    req_level     = priority_bottom + req_scan[2:0] + 3'd1;
    isr_top_level = priority_bottom + isr_scan[2:0] + 3'd1;
    // A request must be strictly higher than every in-service level.
    res_ok        = req_scan[3] && (!isr_scan[3] || (req_scan[2:0] < isr_scan[2:0]));
    resolved      = res_ok ? (NUM_IRQ'(1) << req_level) : '0;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      inta_n_q <= 1'b1;
    end else begin
      state    <= state_d;
      inta_n_q <= inta_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (resolved != '0) state_d = REQ;
      REQ:     if (inta_fall)      state_d = ACK1;
      ACK1:    if (inta_rise)      state_d = GAP;
      GAP:     if (inta_fall)      state_d = ACK2;
      ACK2:    if (inta_rise)      state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  // Output / datapath logic (next values of the registered outputs)
  always_comb begin
    int_out_d         = int_out;
    acknowledge_d     = 1'b0;
    hpi_d             = '0;
    lat_d             = lat;
    lat_level_d       = lat_level;
    spurious_d        = spurious;
    data_out_d        = data_out;
    data_out_enable_d = data_out_enable;
    bottom_d          = priority_bottom;
    rotate_aeoi_d     = rotate_aeoi;
    aeoi_clr          = '0;
    ocw_clr           = '0;

    case (state)
      IDLE: if (resolved != '0) int_out_d = 1'b1;
      REQ: begin
        // int_out stays up even if the request is withdrawn meanwhile.
        if (inta_fall) begin
          int_out_d = 1'b0;
          lat_d     = resolved;
          if (resolved == '0) begin
            lat_level_d = 3'd7;
            spurious_d  = 1'b1;
          end else begin
            lat_level_d   = req_level;
            spurious_d    = 1'b0;
            acknowledge_d = 1'b1;
            hpi_d         = resolved;
          end
        end
      end
      GAP: begin
        if (inta_fall) begin
          data_out_d        = {vector_base, lat_level};
          data_out_enable_d = 1'b1;
        end
      end
      ACK2: begin
        if (inta_rise) begin
          data_out_d        = '0;
          data_out_enable_d = 1'b0;
          if (auto_eoi_mode && !spurious) begin
            aeoi_clr = lat;
            if (rotate_aeoi) bottom_d = lat_level;
          end
        end
      end
      default: ;
    endcase

    // OCW2 is decoded after AEOI so its rotation overrides on conflict.
    if (eoi_command_valid) begin
      case (eoi_command)
        3'b001: if (isr_scan[3]) ocw_clr = NUM_IRQ'(1) << isr_top_level;
        3'b011: ocw_clr = NUM_IRQ'(1) << eoi_level;
        3'b101: begin
          if (isr_scan[3]) begin
            ocw_clr  = NUM_IRQ'(1) << isr_top_level;
            bottom_d = isr_top_level;
          end
        end
        3'b111: begin
          ocw_clr  = NUM_IRQ'(1) << eoi_level;
          bottom_d = eoi_level;
        end
        3'b110: bottom_d = eoi_level;
        3'b100: rotate_aeoi_d = 1'b1;
        3'b000: rotate_aeoi_d = 1'b0;
        default: ;
      endcase
    end

    eoi_d = aeoi_clr | ocw_clr;
  end

  // Output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      int_out                    <= 1'b0;
      acknowledge                <= 1'b0;
      highest_priority_interrupt <= '0;
      end_of_interrupt           <= '0;
      data_out                   <= '0;
      data_out_enable            <= 1'b0;
      priority_bottom            <= 3'd7;
      lat                        <= '0;
      lat_level                  <= '0;
      spurious                   <= 1'b0;
      rotate_aeoi                <= 1'b0;
    end else begin
      int_out                    <= int_out_d;
      acknowledge                <= acknowledge_d;
      highest_priority_interrupt <= hpi_d;
      end_of_interrupt           <= eoi_d;
      data_out                   <= data_out_d;
      data_out_enable            <= data_out_enable_d;
      priority_bottom            <= bottom_d;
      lat                        <= lat_d;
      lat_level                  <= lat_level_d;
      spurious                   <= spurious_d;
      rotate_aeoi                <= rotate_aeoi_d;
    end
  end

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
module tb_interrupt_ack_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] interrupt_request, in_service_register;
  logic       inta_n, auto_eoi_mode;
  logic [4:0] vector_base;
  logic       eoi_command_valid;
  logic [2:0] eoi_command, eoi_level;
  logic       int_out, acknowledge, data_out_enable;
  logic [7:0] highest_priority_interrupt, end_of_interrupt, data_out;
  logic [2:0] priority_bottom;

  int checks = 0;
  int errors = 0;

  interrupt_ack_sequencer dut (
    .clk                        (clk),
    .reset                      (reset),
    .interrupt_request          (interrupt_request),
    .in_service_register        (in_service_register),
    .inta_n                     (inta_n),
    .auto_eoi_mode              (auto_eoi_mode),
    .vector_base                (vector_base),
    .eoi_command_valid          (eoi_command_valid),
    .eoi_command                (eoi_command),
    .eoi_level                  (eoi_level),
    .int_out                    (int_out),
    .acknowledge                (acknowledge),
    .highest_priority_interrupt (highest_priority_interrupt),
    .end_of_interrupt           (end_of_interrupt),
    .data_out                   (data_out),
    .data_out_enable            (data_out_enable),
    .priority_bottom            (priority_bottom)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req, isr;
    logic       inta, aeoi, ev;
    logic [2:0] cmd, lvl;
    logic       io, ack;
    logic [7:0] hpi, eoi, dout;
    logic       doe;
    logic [2:0] bot;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [7:0] req, logic [7:0] isr, logic inta,
                              logic aeoi, logic ev, logic [2:0] cmd, logic [2:0] lvl,
                              logic io, logic ack, logic [7:0] hpi, logic [7:0] eoi,
                              logic [7:0] dout, logic doe, logic [2:0] bot);
    vec_t v;
    v.req = req; v.isr = isr; v.inta = inta; v.aeoi = aeoi; v.ev = ev;
    v.cmd = cmd; v.lvl = lvl; v.io = io; v.ack = ack; v.hpi = hpi;
    v.eoi = eoi; v.dout = dout; v.doe = doe; v.bot = bot;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    interrupt_request   = v.req;
    in_service_register = v.isr;
    inta_n              = v.inta;
    auto_eoi_mode       = v.aeoi;
    eoi_command_valid   = v.ev;
    eoi_command         = v.cmd;
    eoi_level           = v.lvl;
  endtask

  task automatic check(input vec_t v, input string name);
    checks++;
    if ({int_out, acknowledge, highest_priority_interrupt, end_of_interrupt,
         data_out, data_out_enable, priority_bottom} !==
        {v.io, v.ack, v.hpi, v.eoi, v.dout, v.doe, v.bot}) begin
      errors++;
      $display("FAIL %s got io=%0b ack=%0b hpi=%h eoi=%h dout=%h doe=%0b bot=%0d want io=%0b ack=%0b hpi=%h eoi=%h dout=%h doe=%0b bot=%0d",
               name, int_out, acknowledge, highest_priority_interrupt, end_of_interrupt,
               data_out, data_out_enable, priority_bottom,
               v.io, v.ack, v.hpi, v.eoi, v.dout, v.doe, v.bot);
    end
  endtask

  // Drive one record, clock it, and sample 1 time unit after the edge.
  task automatic step(input vec_t v, input string name);
    drive(v);
    @(posedge clk);
    #1;
    check(v, name);
  endtask

  task automatic run_range(input int lo, input int hi, input string tag);
    for (int i = lo; i <= hi; i++) step(tbl[i], $sformatf("%s_%0d", tag, i));
  endtask

  vec_t idle_v, rst_v;

  initial begin
    vector_base = 5'h11;
    idle_v = mk(8'h00, 8'h00, 1, 0, 0, 3'b010, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 7);
    drive(idle_v);
    reset = 1'b1;

    //          req    isr    inta aeoi ev cmd     lvl io ack hpi    eoi    dout   doe bot
    // 0-7: single request IR3, AEOI off
    tbl.push_back(mk(8'h08, 8'h00, 1, 0, 0, 3'b010, 0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 7));
    tbl.push_back(mk(8'h08, 8'h00, 1, 0, 0, 3'b010, 0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 7));
    tbl.push_back(mk(8'h08, 8'h00, 0, 0, 0, 3'b010, 0, 0, 1, 8'h08, 8'h00, 8'h00, 0, 7));
    tbl.push_back(mk(8'h00, 8'h08, 0, 0, 0, 3'b010, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 7));
    tbl.push_back(mk(8'h00, 8'h08, 1, 0, 0, 3'b010, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 7));
    tbl.push_back(mk(8'h00, 8'h08, 0, 0, 0, 3'b010, 0, 0, 0, 8'h00, 8'h00, 8'h8B, 1, 7));
    tbl.push_back(mk(8'h00, 8'h08, 0, 0, 0, 3'b010, 0, 0, 0, 8'h00, 8'h00, 8'h8B, 1, 7));
    tbl.push_back(mk(8'h00, 8'h08, 1, 0, 0, 3'b010, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 7));
    // 8-14: nesting, IR2 in service, IR1 wins over IR4; then IR1 blocked by IR0
    tbl.push_back(mk(8'h12, 8'h04, 1, 0, 0, 3'b010, 0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 7));
    tbl.push_back(mk(8'h12, 8'h04, 0, 0, 0, 3'b010, 0, 0, 1, 8'h02, 8'h00, 8'h00, 0, 7));
    tbl.push_back(mk(8'h10, 8'h06, 1, 0, 0, 3'b010, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 7));
    tbl.push_back(mk(8'h10, 8'h06, 0, 0, 0, 3'b010, 0, 0, 0, 8'h00, 8'h00, 8'h89, 1, 7));
    tbl.push_back(mk(8'h00, 8'h06, 1, 0, 0, 3'b010, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 7));
    tbl.push_back(mk(8'h02, 8'h01, 1, 0, 0, 3'b010, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 7));
    tbl.push_back(mk(8'h02, 8'h01, 1, 0, 0, 3'b010, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 7));
    // 15-26: AEOI rotate; concurrent OCW2 specific EOI ORs into the clear vector
    tbl.push_back(mk(8'h00, 8'h00, 1, 1, 1, 3'b100, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 7));
    tbl.push_back(mk(8'h20, 8'h00, 1, 1, 0, 3'b010, 0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 7));
    tbl.push_back(mk(8'h20, 8'h00, 0, 1, 0, 3'b010, 0, 0, 1, 8'h20, 8'h00, 8'h00, 0, 7));
    tbl.push_back(mk(8'h00, 8'h20, 1, 1, 0, 3'b010, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 7));
    tbl.push_back(mk(8'h00, 8'h20, 0, 1, 0, 3'b010, 0, 0, 0, 8'h00, 8'h00, 8'h8D, 1, 7));
    tbl.push_back(mk(8'h00, 8'h20, 1, 1, 1, 3'b011, 0, 0, 0, 8'h00, 8'h21, 8'h00, 0, 5));
    tbl.push_back(mk(8'h00, 8'h00, 1, 1, 0, 3'b010, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 5));
    tbl.push_back(mk(8'h41, 8'h00, 1, 1, 0, 3'b010, 0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 5));
    tbl.push_back(mk(8'h41, 8'h00, 0, 1, 0, 3'b010, 0, 0, 1, 8'h40, 8'h00, 8'h00, 0, 5));
    tbl.push_back(mk(8'h00, 8'h40, 1, 1, 0, 3'b010, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 5));
    tbl.push_back(mk(8'h00, 8'h40, 0, 1, 0, 3'b010, 0, 0, 0, 8'h00, 8'h00, 8'h8E, 1, 5));
    tbl.push_back(mk(8'h00, 8'h40, 1, 1, 0, 3'b010, 0, 0, 0, 8'h00, 8'h40, 8'h00, 0, 6));
    // 27-35: OCW2 commands
    tbl.push_back(mk(8'h00, 8'h00, 1, 0, 1, 3'b000, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 6));
    tbl.push_back(mk(8'h00, 8'h00, 1, 0, 1, 3'b110, 7, 0, 0, 8'h00, 8'h00, 8'h00, 0, 7));
    tbl.push_back(mk(8'h00, 8'h90, 1, 0, 1, 3'b001, 0, 0, 0, 8'h00, 8'h10, 8'h00, 0, 7));
    tbl.push_back(mk(8'h00, 8'h90, 1, 0, 1, 3'b111, 7, 0, 0, 8'h00, 8'h80, 8'h00, 0, 7));
    tbl.push_back(mk(8'h00, 8'h90, 1, 0, 1, 3'b110, 2, 0, 0, 8'h00, 8'h00, 8'h00, 0, 2));
    tbl.push_back(mk(8'h00, 8'h00, 1, 0, 1, 3'b001, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 2));
    tbl.push_back(mk(8'h00, 8'h90, 1, 0, 1, 3'b101, 0, 0, 0, 8'h00, 8'h10, 8'h00, 0, 4));
    tbl.push_back(mk(8'h00, 8'h90, 1, 0, 1, 3'b011, 7, 0, 0, 8'h00, 8'h80, 8'h00, 0, 4));
    tbl.push_back(mk(8'h00, 8'h00, 1, 0, 1, 3'b110, 7, 0, 0, 8'h00, 8'h00, 8'h00, 0, 7));
    // 36-41: spurious, request withdrawn before INTA; AEOI on but no clear
    tbl.push_back(mk(8'h04, 8'h00, 1, 1, 0, 3'b010, 0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 7));
    tbl.push_back(mk(8'h00, 8'h00, 1, 1, 0, 3'b010, 0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 7));
    tbl.push_back(mk(8'h00, 8'h00, 0, 1, 0, 3'b010, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 7));
    tbl.push_back(mk(8'h00, 8'h00, 1, 1, 0, 3'b010, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 7));
    tbl.push_back(mk(8'h00, 8'h00, 0, 1, 0, 3'b010, 0, 0, 0, 8'h00, 8'h00, 8'h8F, 1, 7));
    tbl.push_back(mk(8'h00, 8'h00, 1, 1, 0, 3'b010, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 7));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check(idle_v, "reset_state");
    reset = 1'b0;

    run_range(0, 7, "single");
    run_range(8, 14, "nest");
    run_range(15, 26, "aeoi_rot");
    run_range(27, 35, "ocw2");
    run_range(36, 41, "spurious");

    // Reset in GAP with a rotated pointer, then a fresh request completes
    step(mk(8'h00, 8'h00, 1, 0, 1, 3'b110, 3, 0, 0, 8'h00, 8'h00, 8'h00, 0, 3), "rst_setbot");
    step(mk(8'h08, 8'h00, 1, 0, 0, 3'b010, 0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 3), "rst_req");
    step(mk(8'h08, 8'h00, 0, 0, 0, 3'b010, 0, 0, 1, 8'h08, 8'h00, 8'h00, 0, 3), "rst_ack");
    step(mk(8'h00, 8'h08, 1, 0, 0, 3'b010, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 3), "rst_gap");
    #2 reset = 1'b1;
    #1 check(idle_v, "rst_async");
    rst_v = idle_v;
    drive(rst_v);
    @(posedge clk);
    #1 check(idle_v, "rst_hold");
    reset = 1'b0;
    run_range(0, 7, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/interrupt_ack_sequencer.md
Name: interrupt_ack_sequencer

Overview:
- Sequences the in-service datapath of the 8259A-style controller.
- Resolves the highest-priority pending request against the current in-service bits, drives INT, and runs the two-pulse 8086-mode INTA handshake.
- Emits the one-cycle acknowledge and set-vector that latch the in-service register, puts the vector byte on the data bus, and emits end_of_interrupt clear vectors for AEOI and OCW2 EOI commands.
- Owns the rotating priority pointer.

Parameters:
- NUM_IRQ, 8, number of interrupt levels; fixed at 8, 3-bit level encoding.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- interrupt_request  in  8  pending requests, already masked (IRR & ~IMR)
- in_service_register  in  8  current ISR contents
- inta_n  in  1  CPU interrupt acknowledge, active-low, synchronous to clk
- auto_eoi_mode  in  1  ICW4 AEOI bit
- vector_base  in  5  ICW2 T7-T3
- eoi_command_valid  in  1  one-cycle pulse on an OCW2 write
- eoi_command  in  3  OCW2 D7-D5 (R, SL, EOI)
- eoi_level  in  3  OCW2 L2-L0
- int_out  out  1  interrupt request to CPU
- acknowledge  out  1  one-cycle pulse; ISR latches highest_priority_interrupt
- highest_priority_interrupt  out  8  one-hot level being acknowledged
- end_of_interrupt  out  8  one-hot ISR clear vector, valid for one cycle
- data_out  out  8  vector byte
- data_out_enable  out  1  drive data bus
- priority_bottom  out  3  lowest-priority level

Behaviour:
- Reset, asynchronous: state IDLE; all outputs 0 except priority_bottom=7 (IR0 highest); rotate_aeoi flag=0; inta_n history register=1.
- Priority order: highest is (priority_bottom+1) mod 8, descending with wrap.
- resolved: one-hot highest-priority request bit strictly higher in priority than every set ISR bit. Equal or lower priority is blocked.
- Falling edge of INTA: inta_n_q=1 and inta_n=0. Rising edge: the inverse.
- FSM:
  - IDLE: resolved!=0 -> REQ; int_out=1 from the next cycle.
  - REQ: int_out held 1 even if the request is withdrawn.
    - On INTA falling edge: latch resolved into lat; int_out=0; goto ACK1.
    - If resolved=0 at that edge: spurious; lat_level=7, spurious flag=1.
    - Same cycle, non-spurious only: acknowledge=1 and highest_priority_interrupt=lat for exactly one cycle. Spurious: acknowledge=0, highest_priority_interrupt=0.
  - ACK1: INTA rising edge -> GAP.
  - GAP: INTA falling edge -> data_out={vector_base,lat_level}, data_out_enable=1 from the next cycle; goto ACK2.
  - ACK2: INTA rising edge -> data_out_enable=0 and data_out=0 next cycle; goto IDLE.
    - If auto_eoi_mode and not spurious: end_of_interrupt=lat for one cycle.
    - If additionally rotate_aeoi: priority_bottom=lat_level.
- OCW2 decode, accepted in any state when eoi_command_valid=1; outputs take effect the next cycle:
  - 001 non-specific EOI: clear the highest-priority set ISR bit. No pulse if ISR=0.
  - 011 specific EOI: clear bit eoi_level.
  - 101 rotate non-specific: as 001, then priority_bottom=cleared level (no change if ISR=0).
  - 111 rotate specific: clear eoi_level; priority_bottom=eoi_level.
  - 110 set priority: priority_bottom=eoi_level, no clear.
  - 100: rotate_aeoi=1. 000: rotate_aeoi=0. 010: no-op.
- Simultaneous AEOI and OCW2 EOI: end_of_interrupt is the OR of both. On conflicting rotation, the OCW2 rotation wins.
- An INTA edge in IDLE is ignored. A falling edge arriving before the rising edge in ACK1/ACK2 is impossible by construction and needs no handling.
- Reset mid-handshake returns to IDLE immediately; data_out_enable drops asynchronously.

Test Plan:
- Single request: interrupt_request=0x08, ISR=0, vector_base=0x11, two INTA pulses -> int_out=1; acknowledge pulse with highest_priority_interrupt=0x08 on the first falling edge; data_out=0x8B and data_out_enable during the second pulse; no end_of_interrupt (AEOI off).
- Nesting: ISR=0x04, requests 0x12 -> resolved IR1 only; ISR=0x01 with request 0x02 -> int_out stays 0.
- AEOI with rotate: auto_eoi_mode=1, OCW2 100 sent, request 0x20 -> end_of_interrupt=0x20 one cycle after the second rising edge; priority_bottom=5, so IR6 becomes highest.
- OCW2 commands with ISR=0x90, bottom=7:
  - 001 -> end_of_interrupt=0x10.
  - 111 with level 7 -> 0x80 and bottom=7.
  - 110 with level 2 -> bottom=2, no pulse.
  - 001 with ISR=0 -> no pulse.
- Spurious: request 0x04 raised, dropped before the first INTA -> no acknowledge; data_out={vector_base,3'b111}.
- Reset asserted in GAP -> all outputs 0 and bottom=7 immediately; a fresh request then completes normally.
